// File: rtl/hazard_stall_ctrl_pkg.sv
// ============================================================================
// Module  : hazard_stall_ctrl_pkg
// Brief   : Shared types and constants for the hazard stall/flush sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_stall_ctrl_pkg;

  // Sequencer state: IDLE evaluates hazards, HOLD finishes a multi-cycle stall
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Number of stall cycles a detected hazard needs
  typedef logic [1:0] stall_n_t;
  localparam stall_n_t STALL_NONE = 2'd0;
  localparam stall_n_t STALL_ONE  = 2'd1;
  localparam stall_n_t STALL_TWO  = 2'd2;

  // $zero is hardwired, so it never carries a real dependency
  localparam int unsigned ZERO_REG = 0;

endpackage

`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
// ============================================================================
// Module  : hazard_stall_ctrl_if
// Brief   : Pipeline-side bundle of hazard inputs and stall/flush controls.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_stall_ctrl_if #(
  parameter int NB_ADDR = 5,
  parameter int NB_CNT  = 32
);

  logic               i_enable;
  logic [NB_ADDR-1:0] i_rs_id;
  logic [NB_ADDR-1:0] i_rt_id;
  logic               i_uses_rs_id;
  logic               i_uses_rt_id;
  logic               i_branch_id;
  logic               i_branch_taken;
  logic [NB_ADDR-1:0] i_rd_id_ex;
  logic               i_regWrite_id_ex;
  logic               i_memRead_id_ex;
  logic [NB_ADDR-1:0] i_rd_ex_m;
  logic               i_memRead_ex_m;
  logic               o_pc_write;
  logic               o_if_id_write;
  logic               o_id_ex_bubble;
  logic               o_if_id_flush;
  logic               o_busy;
  logic [NB_CNT-1:0]  o_stall_count;

  // Pipeline datapath side: supplies stage info, consumes controls
  modport master (
    output i_enable, i_rs_id, i_rt_id, i_uses_rs_id, i_uses_rt_id,
           i_branch_id, i_branch_taken, i_rd_id_ex, i_regWrite_id_ex,
           i_memRead_id_ex, i_rd_ex_m, i_memRead_ex_m,
    input  o_pc_write, o_if_id_write, o_id_ex_bubble, o_if_id_flush,
           o_busy, o_stall_count
  );

  // Hazard controller side
  modport slave (
    input  i_enable, i_rs_id, i_rt_id, i_uses_rs_id, i_uses_rt_id,
           i_branch_id, i_branch_taken, i_rd_id_ex, i_regWrite_id_ex,
           i_memRead_id_ex, i_rd_ex_m, i_memRead_ex_m,
    output o_pc_write, o_if_id_write, o_id_ex_bubble, o_if_id_flush,
           o_busy, o_stall_count
  );

endinterface

`default_nettype wire

// File: rtl/hazard_stall_ctrl_match.sv
// ============================================================================
// Module  : hazard_match
// Brief   : Combinational rs/rt vs destination compare, ignoring $zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_match
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int NB_ADDR = 5
) (
  input  wire logic [NB_ADDR-1:0] i_rs,
  input  wire logic [NB_ADDR-1:0] i_rt,
  input  wire logic               i_uses_rs,
  input  wire logic               i_uses_rt,
  input  wire logic [NB_ADDR-1:0] i_rd,
  output logic                    o_match
);

  logic w_rd_nz;

  assign w_rd_nz = (i_rd != NB_ADDR'(ZERO_REG));
  assign o_match = w_rd_nz &&
                   ((i_uses_rs && (i_rs == i_rd)) ||
                    (i_uses_rt && (i_rt == i_rd)));

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module  : hazard_stall_ctrl
// Brief   : Load-use / branch-operand stall and taken-branch flush sequencer.
//           Optional stall performance counter: define HAZARD_PERF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int NB_ADDR = 5,
  parameter int NB_CNT  = 32
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst_n,
  hazard_stall_ctrl_if.slave io_hz
);

  logic     w_m_ex;
  logic     w_m_m;
  stall_n_t w_n;
  logic     w_stall;
  state_t   r_state;
  stall_n_t r_hold_cnt;

  hazard_match #(.NB_ADDR(NB_ADDR)) u_match_ex (
    .i_rs      (io_hz.i_rs_id),
    .i_rt      (io_hz.i_rt_id),
    .i_uses_rs (io_hz.i_uses_rs_id),
    .i_uses_rt (io_hz.i_uses_rt_id),
    .i_rd      (io_hz.i_rd_id_ex),
    .o_match   (w_m_ex)
  );

  hazard_match #(.NB_ADDR(NB_ADDR)) u_match_m (
    .i_rs      (io_hz.i_rs_id),
    .i_rt      (io_hz.i_rt_id),
    .i_uses_rs (io_hz.i_uses_rs_id),
    .i_uses_rt (io_hz.i_uses_rt_id),
    .i_rd      (io_hz.i_rd_ex_m),
    .o_match   (w_m_m)
  );

  // Required stall cycles; checked in priority order so the largest wins
  always_comb begin
    w_n = STALL_NONE;
    if (io_hz.i_memRead_id_ex && w_m_ex && io_hz.i_branch_id) begin
      w_n = STALL_TWO;
    end else if ((io_hz.i_memRead_id_ex && w_m_ex) ||
                 (io_hz.i_regWrite_id_ex && !io_hz.i_memRead_id_ex &&
                  w_m_ex && io_hz.i_branch_id) ||
                 (io_hz.i_memRead_ex_m && w_m_m && io_hz.i_branch_id)) begin
      w_n = STALL_ONE;
    end
  end

  // HOLD keeps stalling without looking at the (stale) hazard inputs
  assign w_stall = (r_state == HOLD) || (w_n != STALL_NONE);

  // Sequencer: only a two-cycle hazard needs HOLD; one-cycle ones re-evaluate
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_hold_cnt <= STALL_NONE;
    end else if (io_hz.i_enable) begin
      case (r_state)
        IDLE: begin
          if (w_n == STALL_TWO) begin
            r_state    <= HOLD;
            r_hold_cnt <= STALL_TWO - STALL_ONE;
          end
        end
        HOLD: begin
          r_hold_cnt <= r_hold_cnt - STALL_ONE;
          if (r_hold_cnt == STALL_ONE) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_hold_cnt <= STALL_NONE;
        end
      endcase
    end
  end

  // Mealy control outputs; a stall masks the flush since branch operands are stale
  always_comb begin
    io_hz.o_pc_write     = 1'b0;
    io_hz.o_if_id_write  = 1'b0;
    io_hz.o_id_ex_bubble = 1'b0;
    io_hz.o_if_id_flush  = 1'b0;
    if (i_rst_n && io_hz.i_enable) begin
      io_hz.o_pc_write     = !w_stall;
      io_hz.o_if_id_write  = !w_stall;
      io_hz.o_id_ex_bubble = w_stall;
      io_hz.o_if_id_flush  = io_hz.i_branch_taken && !w_stall;
    end
  end

  assign io_hz.o_busy = i_rst_n && (r_state == HOLD);

`ifdef HAZARD_PERF_CNT_EN
  logic [NB_CNT-1:0] r_stall_cnt;

  // Saturating count of enabled stall cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (io_hz.i_enable && w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + NB_CNT'(1);
    end
  end

  assign io_hz.o_stall_count = r_stall_cnt;
`else
  assign io_hz.o_stall_count = {NB_CNT{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// Module  : tb_hazard_stall_ctrl
// Brief   : Directed bench for hazard_stall_ctrl (honours HAZARD_PERF_CNT_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

  localparam int NB_ADDR = 5;
  localparam int NB_CNT  = 32;

  // Output vector order: {pc_write, if_id_write, bubble, flush, busy}
  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_STALL = 5'b00100;
  localparam logic [4:0] C_HOLD  = 5'b00101;
  localparam logic [4:0] C_FLUSH = 5'b11010;
  localparam logic [4:0] C_OFF   = 5'b00000;
  localparam logic [4:0] C_FROZE = 5'b00001;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_pass      = 0;
  int   n_total     = 0;
  int   exp_stalls  = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.NB_ADDR(NB_ADDR), .NB_CNT(NB_CNT)) hz ();

  hazard_stall_ctrl #(.NB_ADDR(NB_ADDR), .NB_CNT(NB_CNT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_hz   (hz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [4:0] exp);
    logic [31:0] exp_cnt;
`ifdef HAZARD_PERF_CNT_EN
    exp_cnt = exp_stalls;
`else
    exp_cnt = 0;
`endif
    chk({tag, "/cnt"}, hz.o_stall_count, exp_cnt);
    chk(tag, {27'd0, hz.o_pc_write, hz.o_if_id_write, hz.o_id_ex_bubble,
              hz.o_if_id_flush, hz.o_busy}, {27'd0, exp});
    if (rst_n && hz.i_enable && !exp[4]) exp_stalls++;
  endtask

  task automatic clr();
    hz.i_enable         = 1'b1;
    hz.i_rs_id          = '0;
    hz.i_rt_id          = '0;
    hz.i_uses_rs_id     = 1'b0;
    hz.i_uses_rt_id     = 1'b0;
    hz.i_branch_id      = 1'b0;
    hz.i_branch_taken   = 1'b0;
    hz.i_rd_id_ex       = '0;
    hz.i_regWrite_id_ex = 1'b0;
    hz.i_memRead_id_ex  = 1'b0;
    hz.i_rd_ex_m        = '0;
    hz.i_memRead_ex_m   = 1'b0;
  endtask

  // lw $rd in ID/EX, ID instruction reads rs=rd
  task automatic load_use(input logic [NB_ADDR-1:0] rd, input logic br);
    clr();
    hz.i_memRead_id_ex  = 1'b1;
    hz.i_regWrite_id_ex = 1'b1;
    hz.i_rd_id_ex       = rd;
    hz.i_rs_id          = rd;
    hz.i_uses_rs_id     = 1'b1;
    hz.i_branch_id      = br;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    load_use(5'd3, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk_out("reset", C_OFF);

    @(negedge clk); rst_n = 1'b1; clr();
    #2 chk_out("idle", C_RUN);

    // load-use, non-branch: one bubble
    @(negedge clk); load_use(5'd3, 1'b0);
    #2 chk_out("lu_stall", C_STALL);
    @(negedge clk); clr();
    #2 chk_out("lu_after", C_RUN);

    // load -> beq: two stalls, busy in second
    @(negedge clk); load_use(5'd5, 1'b1);
    #2 chk_out("lbr_s1", C_STALL);
    @(negedge clk);
    #2 chk_out("lbr_hold", C_HOLD);
    @(negedge clk); clr();
    #2 chk_out("lbr_done", C_RUN);

    // ALU -> beq on rt: one stall
    @(negedge clk); clr();
    hz.i_regWrite_id_ex = 1'b1; hz.i_rd_id_ex = 5'd7;
    hz.i_rt_id = 5'd7; hz.i_uses_rt_id = 1'b1; hz.i_branch_id = 1'b1;
    #2 chk_out("alu_br", C_STALL);
    hz.i_branch_id = 1'b0;
    #1 chk_out("alu_nobr", C_RUN);
    @(negedge clk); clr();
    #2 chk_out("alu_after", C_RUN);

    // load in EX/MEM feeding a branch: one stall
    @(negedge clk); clr();
    hz.i_memRead_ex_m = 1'b1; hz.i_rd_ex_m = 5'd9;
    hz.i_rs_id = 5'd9; hz.i_uses_rs_id = 1'b1; hz.i_branch_id = 1'b1;
    #2 chk_out("mem_br", C_STALL);

    // taken branch during stall is ignored, then flushes once resolved
    @(negedge clk); load_use(5'd4, 1'b0); hz.i_branch_taken = 1'b1;
    #2 chk_out("br_in_stall", C_STALL);
    @(negedge clk); clr(); hz.i_branch_taken = 1'b1;
    #2 chk_out("br_flush", C_FLUSH);

    // $0 destination and an unused operand never stall
    @(negedge clk); load_use(5'd0, 1'b1);
    #2 chk_out("zero_reg", C_RUN);
    @(negedge clk); load_use(5'd3, 1'b0); hz.i_uses_rs_id = 1'b0;
    #2 chk_out("unused_rs", C_RUN);

    // disabled with a two-cycle hazard: outputs off, no HOLD entry
    @(negedge clk); load_use(5'd6, 1'b1); hz.i_enable = 1'b0;
    #2 chk_out("dis_idle", C_OFF);
    @(negedge clk); clr();
    #2 chk_out("dis_noenter", C_RUN);

    // HOLD frozen by enable=0 for three cycles
    @(negedge clk); load_use(5'd5, 1'b1);
    #2 chk_out("frz_s1", C_STALL);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); hz.i_enable = 1'b0;
      #2 chk_out($sformatf("frz_%0d", i), C_FROZE);
    end
    @(negedge clk); hz.i_enable = 1'b1;
    #2 chk_out("frz_hold", C_HOLD);
    @(negedge clk); clr();
    #2 chk_out("frz_done", C_RUN);

    // reset in the middle of HOLD
    @(negedge clk); load_use(5'd8, 1'b1);
    #2 chk_out("rst_s1", C_STALL);
    @(negedge clk);
    #2 chk_out("rst_hold", C_HOLD);
    #1 rst_n = 1'b0; exp_stalls = 0;
    #1 chk_out("rst_mid", C_OFF);
    @(negedge clk); rst_n = 1'b1; clr();
    #2 chk_out("rst_release", C_RUN);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
